// File: rtl/layer_composer.sv
// Per-pixel read-index generator and three-source priority merger feeding the palette stage.
// Pipeline: stage 0 issues the read index, buffer data returns the next cycle and is composed into pixel_out.
module layer_composer #(
    parameter int H_ACTIVE = 640,
    parameter int IDX_MAX  = 767
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_start,
    input  logic       next_pixel,
    input  logic [7:0] hscale,
    input  logic [9:0] hstart,
    input  logic [9:0] hstop,
    input  logic [7:0] border_color,
    input  logic       layer0_enabled,
    input  logic       layer1_enabled,
    input  logic       sprites_enabled,
    output logic [9:0] composer_rd_idx,
    input  logic [7:0] layer0_rd_data,
    input  logic [7:0] layer1_rd_data,
    input  logic [7:0] sprite_rd_data,
    input  logic [1:0] sprite_rd_z,
    output logic [7:0] pixel_out,
    output logic       pixel_valid,
    output logic       line_done
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [16:0] ACC_MAX = 17'((IDX_MAX << 7) | 127);
    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [16:0] acc_q, acc_d;
    logic        v1_q, win1_q, last1_q;
    logic        pv_q, last2_q;
    logic [7:0]  pix_q, pix_d;
    logic        ld_q;

    logic        accept;
    logic        in_win;
    logic [17:0] acc_sum;
    logic [16:0] acc_step;
    logic [7:0]  composed;
    logic        l0_opaque, l1_opaque, spr_present;

    assign accept   = next_pixel && (state_q == S_ACTIVE) && !line_start;
    assign in_win   = (x_q >= hstart) && (x_q < hstop);
    assign acc_sum  = {1'b0, acc_q} + {10'd0, hscale};
    assign acc_step = (acc_sum > {1'b0, ACC_MAX}) ? ACC_MAX : acc_sum[16:0];

    // The index is the integer part of the source accumulator; it holds between accepts.
    assign composer_rd_idx = acc_q[16:7];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        if (line_start) begin
            state_d = S_ACTIVE;
            x_d     = '0;
            acc_d   = '0;
        end else if (accept) begin
            if (in_win) begin
                acc_d = acc_step;
            end
            x_d = x_q + 10'd1;
            if (x_q == X_LAST) begin
                state_d = S_IDLE;
            end
        end
    end

    assign l0_opaque   = layer0_enabled && (layer0_rd_data != 8'd0);
    assign l1_opaque   = layer1_enabled && (layer1_rd_data != 8'd0);
    assign spr_present = sprites_enabled && (sprite_rd_z != 2'd0) && (sprite_rd_data != 8'd0);

    always_comb begin
        composed = 8'd0;
        if (!win1_q) begin
            composed = border_color;
        end else if (spr_present && sprite_rd_z == 2'd3) begin
            composed = sprite_rd_data;
        end else if (l1_opaque) begin
            composed = layer1_rd_data;
        end else if (spr_present && sprite_rd_z == 2'd2) begin
            composed = sprite_rd_data;
        end else if (l0_opaque) begin
            composed = layer0_rd_data;
        end else if (spr_present) begin
            composed = sprite_rd_data;
        end
    end

    always_comb begin
        pix_d = pix_q;
        if (v1_q) begin
            pix_d = composed;
        end
    end

    // A restart drops everything not already shown before the line_start cycle,
    // including the pixel whose valid would appear in that very cycle.
    assign pixel_valid = pv_q && !line_start;
    assign pixel_out   = pix_q;
    assign line_done   = ld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            v1_q    <= 1'b0;
            win1_q  <= 1'b0;
            last1_q <= 1'b0;
            pv_q    <= 1'b0;
            last2_q <= 1'b0;
            pix_q   <= '0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            v1_q    <= accept;
            win1_q  <= in_win;
            last1_q <= (x_q == X_LAST);
            pv_q    <= v1_q && !line_start;
            last2_q <= last1_q;
            pix_q   <= pix_d;
            ld_q    <= pixel_valid && last2_q;
        end
    end

endmodule

// File: tb/tb_layer_composer.sv
// Randomized bench for layer_composer: line-buffer memories, a pixel-level reference model,
// a per-cycle compare process and a few hand-computed literal checks.
module tb_layer_composer;

  localparam int H_ACTIVE = 640;
  localparam int ACC_MAX  = (767 << 7) | 127;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line_start = 1'b0;
  logic       next_pixel = 1'b0;
  logic [7:0] hscale = 8'd128;
  logic [9:0] hstart = 10'd0;
  logic [9:0] hstop = 10'd640;
  logic [7:0] border_color = 8'd0;
  logic       layer0_enabled = 1'b1;
  logic       layer1_enabled = 1'b1;
  logic       sprites_enabled = 1'b1;
  logic [9:0] composer_rd_idx;
  logic [7:0] layer0_rd_data = 8'd0;
  logic [7:0] layer1_rd_data = 8'd0;
  logic [7:0] sprite_rd_data = 8'd0;
  logic [1:0] sprite_rd_z = 2'd0;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       line_done;

  layer_composer dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_pixel(next_pixel),
    .hscale(hscale), .hstart(hstart), .hstop(hstop), .border_color(border_color),
    .layer0_enabled(layer0_enabled), .layer1_enabled(layer1_enabled),
    .sprites_enabled(sprites_enabled), .composer_rd_idx(composer_rd_idx),
    .layer0_rd_data(layer0_rd_data), .layer1_rd_data(layer1_rd_data),
    .sprite_rd_data(sprite_rd_data), .sprite_rd_z(sprite_rd_z),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid), .line_done(line_done)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- line-buffer memories (1-cycle read latency) ----------------
  logic [7:0] mem0 [768];
  logic [7:0] mem1 [768];
  logic [7:0] sprc [768];
  logic [1:0] sprz [768];

  always @(posedge clk) begin
    layer0_rd_data <= mem0[composer_rd_idx];
    layer1_rd_data <= mem1[composer_rd_idx];
    sprite_rd_data <= sprc[composer_rd_idx];
    sprite_rd_z    <= sprz[composer_rd_idx];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // entry = {due_cycle[31:0], last, value[7:0]}
  logic [40:0] exp_q[$];
  int  ld_due = -1;
  int  ld_seen = 0;
  int  n_lines = 0;

  // behavioural model of the line traversal
  bit  m_active = 0;
  int  m_x = 0;
  int  m_acc = 0;
  int  m_idx_now = 0;

  function automatic logic [7:0] model_pix(input int idx, input bit win);
    bit s, l0, l1;
    if (!win) return border_color;
    s  = sprites_enabled && sprz[idx] != 0 && sprc[idx] != 0;
    l1 = layer1_enabled && mem1[idx] != 0;
    l0 = layer0_enabled && mem0[idx] != 0;
    if (s && sprz[idx] == 3) return sprc[idx];
    if (l1) return mem1[idx];
    if (s && sprz[idx] == 2) return sprc[idx];
    if (l0) return mem0[idx];
    if (s) return sprc[idx];
    return 8'h00;
  endfunction

  // One clock cycle of stimulus, with the model advanced by the same rules.
  task automatic cyc_drive(input bit ls, input bit np);
    bit win;
    logic [7:0] v;
    @(posedge clk); #1;
    line_start = ls;
    next_pixel = np;
    m_idx_now = m_acc >> 7;
    if (ls) begin
      while (exp_q.size() > 0 && int'(exp_q[$][40:9]) >= cyc) void'(exp_q.pop_back());
      m_active = 1; m_x = 0; m_acc = 0;
    end else if (np && m_active) begin
      win = (m_x >= int'(hstart)) && (m_x < int'(hstop));
      v = model_pix(m_acc >> 7, win);
      exp_q.push_back({32'(cyc + 2), (m_x == H_ACTIVE - 1), v});
      if (win) m_acc = (m_acc + int'(hscale) > ACC_MAX) ? ACC_MAX : m_acc + int'(hscale);
      m_x++;
      if (m_x == H_ACTIVE) m_active = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(0, 0);
  endtask

  task automatic finish_line(input int gap_max);
    int guard = 0;
    while (m_active && guard < 5000) begin
      cyc_drive(0, (gap_max == 0) ? 1'b1 : ($urandom_range(0, gap_max) == 0));
      guard++;
    end
    if (m_active) check("line_timeout", 1, 0);
    idle(4);
    n_lines++;
  endtask

  task automatic run_line(input int gap_max);
    cyc_drive(1, 0);
    finish_line(gap_max);
  endtask

  // Single accept, then the literal value two cycles later.
  task automatic lit_pixel(input string name, input logic [7:0] lit);
    cyc_drive(0, 1);
    cyc_drive(0, 0);
    cyc_drive(0, 0);
    #2;
    check({name, "_valid"}, pixel_valid, 1);
    check(name, pixel_out, lit);
  endtask

  function automatic void fill_random();
    for (int i = 0; i < 768; i++) begin
      mem0[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      mem1[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      sprc[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      sprz[i] = 2'($urandom_range(0, 3));
    end
  endfunction

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    bit exp_pv;
    logic [40:0] e;
    exp_pv = (exp_q.size() > 0) && (int'(exp_q[0][40:9]) == cyc);
    check("pixel_valid", pixel_valid, exp_pv);
    if (exp_pv) begin
      e = exp_q.pop_front();
      check("pixel_out", pixel_out, e[7:0]);
      if (e[8]) ld_due = cyc + 1;
    end
    check("line_done", line_done, (ld_due == cyc));
    check("rd_idx", composer_rd_idx, m_idx_now);
    if (line_done) ld_seen++;
  end

  // ---------------- main sequence ----------------
  initial begin
    fill_random();
    #3;
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel_out", pixel_out, 0);
    check("rst_rd_idx", composer_rd_idx, 0);
    check("rst_line_done", line_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // next_pixel while idle is ignored
    for (int i = 0; i < 4; i++) cyc_drive(0, 1);
    idle(3);

    // unity scale, full window, back-to-back
    hscale = 8'd128; hstart = 10'd0; hstop = 10'd640;
    run_line(0);
    check("unity_end_idx", composer_rd_idx, 640);

    // half scale with gaps
    hscale = 8'd64;
    run_line(2);
    check("half_end_idx", composer_rd_idx, 320);

    // maximum step saturates the index
    hscale = 8'd255;
    run_line(0);
    check("sat_end_idx", composer_rd_idx, 767);

    // narrow window with border
    hscale = 8'd128; hstart = 10'd16; hstop = 10'd32; border_color = 8'h2A;
    run_line(1);
    check("window_end_idx", composer_rd_idx, 16);

    // empty window: all border, accumulator frozen
    hstart = 10'd100; hstop = 10'd100; border_color = 8'h5C;
    run_line(0);
    check("empty_win_idx", composer_rd_idx, 0);

    // zero step
    hscale = 8'd0; hstart = 10'd0; hstop = 10'd640;
    run_line(1);
    check("zero_step_idx", composer_rd_idx, 0);

    // priority literals
    hscale = 8'd128; hstart = 10'd0; hstop = 10'd640;
    layer0_enabled = 1; layer1_enabled = 1; sprites_enabled = 1;
    for (int i = 0; i < 6; i++) begin
      mem0[i] = 8'h11; mem1[i] = 8'h22; sprc[i] = 8'h33;
    end
    sprz[0] = 2'd3; sprz[1] = 2'd2; sprz[2] = 2'd2; mem1[2] = 8'h00; sprz[3] = 2'd1;
    mem0[4] = 8'h00; mem1[4] = 8'h00; sprc[4] = 8'h00; sprz[4] = 2'd0; sprz[5] = 2'd1;
    cyc_drive(1, 0);
    lit_pixel("prio_z3", 8'h33);
    lit_pixel("prio_z2", 8'h22);
    lit_pixel("prio_l1clear_z2", 8'h33);
    lit_pixel("prio_z1", 8'h22);
    lit_pixel("prio_transparent", 8'h00);
    layer1_enabled = 0;
    lit_pixel("prio_l1off_z1", 8'h11);
    layer1_enabled = 1;
    idle(3);

    // reset mid-line while a pixel is being shown
    fill_random();
    cyc_drive(1, 0);
    for (int i = 0; i < 10; i++) cyc_drive(0, 1);
    #2;
    check("pre_reset_valid", pixel_valid, 1);
    rst = 1'b1;
    next_pixel = 1'b0;
    exp_q.delete(); ld_due = -1;
    m_active = 0; m_x = 0; m_acc = 0; m_idx_now = 0;
    #1;
    check("reset_mid_valid", pixel_valid, 0);
    check("reset_mid_out", pixel_out, 0);
    check("reset_mid_idx", composer_rd_idx, 0);
    check("reset_mid_ld", line_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc_drive(0, 1);
    idle(2);

    // abort at x=300 with two pixels in flight
    cyc_drive(1, 0);
    for (int i = 0; i < 300; i++) cyc_drive(0, 1);
    cyc_drive(1, 0);
    #2;
    check("abort_suppressed", pixel_valid, 0);
    cyc_drive(0, 1);
    #2;
    check("abort_restart_idx", composer_rd_idx, 0);
    finish_line(1);

    // randomized lines
    for (int l = 0; l < 4; l++) begin
      fill_random();
      hscale = 8'($urandom_range(0, 255));
      hstart = 10'($urandom_range(0, 200));
      hstop  = 10'($urandom_range(100, 700));
      border_color = 8'($urandom);
      layer0_enabled = 1'($urandom); layer1_enabled = 1'($urandom); sprites_enabled = 1'($urandom);
      run_line($urandom_range(0, 2));
    end

    idle(4);
    check("line_done_count", ld_seen, n_lines);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
